arf_accurate: RTL and testbench
===============================

Name: arf_accurate

Overview:
- Exact-arithmetic auto-regressive filter (ARF) datapath: a fixed 28-node data-flow graph of 16 constant multiplies and 12 adds.
- Takes eight 16-bit samples and two 64-bit feedback terms and produces two 64-bit results, out_27 and out_28.
- Serves as the golden reference against arf_variance, which is the same graph built with approximate multipliers (TRUNC_BITS > 0) and is compared output-for-output.

Parameters:
- C1..C8, defaults 3,5,7,9,11,13,15,17: signed 16-bit coefficients for nodes n1..n8.
- K15..K18, defaults 2,3,4,5: signed 16-bit coefficients for nodes n15..n18.
- K23..K26, defaults 6,7,8,9: signed 16-bit coefficients for nodes n23..n26.
- TRUNC_BITS, default 0: low product bits forced to 0 in every multiplier. arf_accurate uses 0; arf_variance instantiates the same RTL with a value > 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample set valid this cycle
- in_1_0 .. in_8_0  in  16 each  signed samples feeding n1..n8
- in_13_1  in  64  signed second operand of n13
- in_14_1  in  64  signed second operand of n14
- out_valid  out  1  outputs valid
- out_27  out  64  signed result of node 27
- out_28  out  64  signed result of node 28

Behaviour:
- Arithmetic rules
  - All values are two's-complement signed.
  - 16-bit inputs and coefficients are sign-extended to 64 bits.
  - Every node result is 64 bits and wraps modulo 2^64; there is no saturation and no overflow flag.
  - Multiply is the low 64 bits of the product, then the low TRUNC_BITS bits are cleared.
- Graph
  - n1..n8 = in_i_0*Ci
  - n9=n1+n2; n10=n3+n4; n11=n5+n6; n12=n7+n8
  - n13=n9+in_13_1; n14=n10+in_14_1
  - n15=n13*K15; n16=n13*K16; n17=n14*K17; n18=n14*K18
  - n19=n15+n17; n20=n16+n18; n21=n19+n11; n22=n20+n12
  - n23=n21*K23; n24=n21*K24; n25=n22*K25; n26=n22*K26
  - out_27=n23+n25; out_28=n24+n26
- Pipeline
  - Stage A registers n11..n14.
  - Stage B registers n21 and n22.
  - Stage C registers out_27 and out_28.
  - Latency is 3 cycles from an in_valid sample edge to out_valid high with the matching results.
  - Throughput is one sample set per cycle with no stalls.
- Valid handling
  - in_valid is delayed through a 3-bit shift register to form out_valid.
  - Data registers load every cycle regardless of in_valid.
  - When out_valid is 0, out_27 and out_28 are don't-care for checking.
- Reset
  - rst_n low clears all pipeline registers, out_valid, out_27 and out_28 to 0 asynchronously.
  - Reset asserted mid-stream discards in-flight samples.
  - After reset release, the first out_valid occurs 3 cycles after the first sampled in_valid.
- Back-to-back and gapped in_valid must each produce exactly one out_valid pulse per input, in order.

Decomposition:
- Shared package arf_pkg holds:
  - word width 64 and sample width 16;
  - the default coefficient constants;
  - a function for the sign-extend-multiply-truncate operation.
- One natural sub-module, arf_mul, implements a constant multiplier with a TRUNC_BITS parameter. It is instantiated 16 times. The approximate variant differs only in this parameter.

Test Plan:
- Reset and zero input
  - Hold rst_n=0: out_valid=0, outputs 0.
  - Release rst_n, all inputs 0 with in_valid=1: 3 cycles later out_27=0, out_28=0.
- Single sample input, positive and negative
  - in_1_0=1, all other inputs 0: out_27=108, out_28=123.
  - in_1_0=16'hFFFF: out_27=-108, out_28=-123 (64-bit sign-extended).
- Feedback inputs
  - in_13_1=1, all others 0: out_27=36, out_28=41.
  - in_14_1=1, all others 0: out_27=64, out_28=73.
  - in_7_0=1, all others 0: out_27=120, out_28=135.
- Streaming
  - Drive the five vectors above on consecutive cycles with in_valid=1.
  - Results appear in order on 5 consecutive out_valid cycles starting 3 cycles after the first.
  - Repeat with one idle cycle inserted: the out_valid pattern reproduces the in_valid pattern delayed by 3.
- Mid-stream reset
  - Assert rst_n=0 with 2 samples in flight.
  - Outputs and out_valid clear immediately, and no stale result appears after release.
- Truncated multiplier variant
  - With TRUNC_BITS=2 and in_1_0=1: n1=0, so out_27=0, out_28=0.
  - Compare random vectors against the TRUNC_BITS=0 build and log the output differences.

Source files
------------

// File: rtl/arf_pkg.sv
// Shared widths, default coefficients and the constant-multiply helper for the
// auto-regressive filter datapath.
package arf_pkg;

    localparam int WORD_W   = 64;
    localparam int SAMPLE_W = 16;

    localparam logic signed [SAMPLE_W-1:0] C1_DEF  = 16'sd3;
    localparam logic signed [SAMPLE_W-1:0] C2_DEF  = 16'sd5;
    localparam logic signed [SAMPLE_W-1:0] C3_DEF  = 16'sd7;
    localparam logic signed [SAMPLE_W-1:0] C4_DEF  = 16'sd9;
    localparam logic signed [SAMPLE_W-1:0] C5_DEF  = 16'sd11;
    localparam logic signed [SAMPLE_W-1:0] C6_DEF  = 16'sd13;
    localparam logic signed [SAMPLE_W-1:0] C7_DEF  = 16'sd15;
    localparam logic signed [SAMPLE_W-1:0] C8_DEF  = 16'sd17;
    localparam logic signed [SAMPLE_W-1:0] K15_DEF = 16'sd2;
    localparam logic signed [SAMPLE_W-1:0] K16_DEF = 16'sd3;
    localparam logic signed [SAMPLE_W-1:0] K17_DEF = 16'sd4;
    localparam logic signed [SAMPLE_W-1:0] K18_DEF = 16'sd5;
    localparam logic signed [SAMPLE_W-1:0] K23_DEF = 16'sd6;
    localparam logic signed [SAMPLE_W-1:0] K24_DEF = 16'sd7;
    localparam logic signed [SAMPLE_W-1:0] K25_DEF = 16'sd8;
    localparam logic signed [SAMPLE_W-1:0] K26_DEF = 16'sd9;

    function automatic logic [WORD_W-1:0] sext_sample(input logic [SAMPLE_W-1:0] s);
        return {{(WORD_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

    // Low 64 product bits equal the signed product mod 2^64, so an unsigned
    // multiply of the sign-extended operands is exact here.
    function automatic logic [WORD_W-1:0] mul_trunc(
        input logic [WORD_W-1:0]   a,
        input logic [SAMPLE_W-1:0] c,
        input int unsigned         trunc_bits
    );
        logic [WORD_W-1:0] prod;
        logic [WORD_W-1:0] mask;
        prod = a * sext_sample(c);
        mask = {WORD_W{1'b1}} << trunc_bits;
        return prod & mask;
    endfunction

endpackage

// File: rtl/arf_mul.sv
// Constant multiplier node; TRUNC_BITS > 0 yields the approximate variant.
module arf_mul
    import arf_pkg::*;
#(
    parameter logic signed [SAMPLE_W-1:0] COEF       = 16'sd1,
    parameter int unsigned                TRUNC_BITS = 0
) (
    input  logic [WORD_W-1:0] a_i,
    output logic [WORD_W-1:0] p_o
);

    assign p_o = mul_trunc(a_i, COEF, TRUNC_BITS);

endmodule

// File: rtl/arf_accurate.sv
// 28-node ARF data-flow graph, three register stages (n11..n14, n21/n22, outputs),
// one sample set per cycle.
module arf_accurate
    import arf_pkg::*;
#(
    parameter logic signed [SAMPLE_W-1:0] C1  = C1_DEF,
    parameter logic signed [SAMPLE_W-1:0] C2  = C2_DEF,
    parameter logic signed [SAMPLE_W-1:0] C3  = C3_DEF,
    parameter logic signed [SAMPLE_W-1:0] C4  = C4_DEF,
    parameter logic signed [SAMPLE_W-1:0] C5  = C5_DEF,
    parameter logic signed [SAMPLE_W-1:0] C6  = C6_DEF,
    parameter logic signed [SAMPLE_W-1:0] C7  = C7_DEF,
    parameter logic signed [SAMPLE_W-1:0] C8  = C8_DEF,
    parameter logic signed [SAMPLE_W-1:0] K15 = K15_DEF,
    parameter logic signed [SAMPLE_W-1:0] K16 = K16_DEF,
    parameter logic signed [SAMPLE_W-1:0] K17 = K17_DEF,
    parameter logic signed [SAMPLE_W-1:0] K18 = K18_DEF,
    parameter logic signed [SAMPLE_W-1:0] K23 = K23_DEF,
    parameter logic signed [SAMPLE_W-1:0] K24 = K24_DEF,
    parameter logic signed [SAMPLE_W-1:0] K25 = K25_DEF,
    parameter logic signed [SAMPLE_W-1:0] K26 = K26_DEF,
    parameter int unsigned                TRUNC_BITS = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_1_0,
    input  logic [SAMPLE_W-1:0] in_2_0,
    input  logic [SAMPLE_W-1:0] in_3_0,
    input  logic [SAMPLE_W-1:0] in_4_0,
    input  logic [SAMPLE_W-1:0] in_5_0,
    input  logic [SAMPLE_W-1:0] in_6_0,
    input  logic [SAMPLE_W-1:0] in_7_0,
    input  logic [SAMPLE_W-1:0] in_8_0,
    input  logic [WORD_W-1:0]   in_13_1,
    input  logic [WORD_W-1:0]   in_14_1,
    output logic                out_valid,
    output logic [WORD_W-1:0]   out_27,
    output logic [WORD_W-1:0]   out_28
);

    localparam logic signed [SAMPLE_W-1:0] C_ARR [8] = '{C1, C2, C3, C4, C5, C6, C7, C8};

    logic [WORD_W-1:0] x [8];
    logic [WORD_W-1:0] n [8];

    assign x[0] = sext_sample(in_1_0);
    assign x[1] = sext_sample(in_2_0);
    assign x[2] = sext_sample(in_3_0);
    assign x[3] = sext_sample(in_4_0);
    assign x[4] = sext_sample(in_5_0);
    assign x[5] = sext_sample(in_6_0);
    assign x[6] = sext_sample(in_7_0);
    assign x[7] = sext_sample(in_8_0);

    for (genvar i = 0; i < 8; i++) begin : g_in_mul
        arf_mul #(.COEF(C_ARR[i]), .TRUNC_BITS(TRUNC_BITS)) u_mul (
            .a_i (x[i]),
            .p_o (n[i])
        );
    end

    logic [WORD_W-1:0] n11_d, n12_d, n13_d, n14_d;
    logic [WORD_W-1:0] n11_q, n12_q, n13_q, n14_q;

    assign n11_d = n[4] + n[5];
    assign n12_d = n[6] + n[7];
    assign n13_d = n[0] + n[1] + in_13_1;
    assign n14_d = n[2] + n[3] + in_14_1;

    logic [WORD_W-1:0] n15, n16, n17, n18;

    arf_mul #(.COEF(K15), .TRUNC_BITS(TRUNC_BITS)) u_n15 (.a_i(n13_q), .p_o(n15));
    arf_mul #(.COEF(K16), .TRUNC_BITS(TRUNC_BITS)) u_n16 (.a_i(n13_q), .p_o(n16));
    arf_mul #(.COEF(K17), .TRUNC_BITS(TRUNC_BITS)) u_n17 (.a_i(n14_q), .p_o(n17));
    arf_mul #(.COEF(K18), .TRUNC_BITS(TRUNC_BITS)) u_n18 (.a_i(n14_q), .p_o(n18));

    logic [WORD_W-1:0] n21_d, n22_d;
    logic [WORD_W-1:0] n21_q, n22_q;

    assign n21_d = n15 + n17 + n11_q;
    assign n22_d = n16 + n18 + n12_q;

    logic [WORD_W-1:0] n23, n24, n25, n26;

    arf_mul #(.COEF(K23), .TRUNC_BITS(TRUNC_BITS)) u_n23 (.a_i(n21_q), .p_o(n23));
    arf_mul #(.COEF(K24), .TRUNC_BITS(TRUNC_BITS)) u_n24 (.a_i(n21_q), .p_o(n24));
    arf_mul #(.COEF(K25), .TRUNC_BITS(TRUNC_BITS)) u_n25 (.a_i(n22_q), .p_o(n25));
    arf_mul #(.COEF(K26), .TRUNC_BITS(TRUNC_BITS)) u_n26 (.a_i(n22_q), .p_o(n26));

    logic [WORD_W-1:0] out_27_d, out_28_d;
    logic [WORD_W-1:0] out_27_q, out_28_q;
    logic [2:0]        valid_q;

    assign out_27_d = n23 + n25;
    assign out_28_d = n24 + n26;

    // Data stages load unconditionally; only the valid shift register qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n11_q    <= '0;
            n12_q    <= '0;
            n13_q    <= '0;
            n14_q    <= '0;
            n21_q    <= '0;
            n22_q    <= '0;
            out_27_q <= '0;
            out_28_q <= '0;
            valid_q  <= '0;
        end else begin
            n11_q    <= n11_d;
            n12_q    <= n12_d;
            n13_q    <= n13_d;
            n14_q    <= n14_d;
            n21_q    <= n21_d;
            n22_q    <= n22_d;
            out_27_q <= out_27_d;
            out_28_q <= out_28_d;
            valid_q  <= {valid_q[1:0], in_valid};
        end
    end

    assign out_valid = valid_q[2];
    assign out_27    = out_27_q;
    assign out_28    = out_28_q;

endmodule

// File: tb/tb_arf_accurate.sv
// Scoreboard bench for arf_accurate: exact build plus a TRUNC_BITS=2 build on the
// same stimulus, each with its own expected-result queue.
module tb_arf_accurate;

    typedef struct packed {
        logic [7:0][15:0] s;
        logic [63:0]      f13;
        logic [63:0]      f14;
    } vec_t;

    typedef struct packed {
        logic [63:0] e27;
        logic [63:0] e28;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_s [8];
    logic [63:0] in_13_1, in_14_1;
    logic        out_valid, out_valid_t;
    logic [63:0] out_27, out_28, out_27_t, out_28_t;

    int   n_vec;
    int   n_err;
    bit   log_diff;
    exp_t q_m[$];
    exp_t q_t[$];

    arf_accurate dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_1_0(in_s[0]), .in_2_0(in_s[1]), .in_3_0(in_s[2]), .in_4_0(in_s[3]),
        .in_5_0(in_s[4]), .in_6_0(in_s[5]), .in_7_0(in_s[6]), .in_8_0(in_s[7]),
        .in_13_1(in_13_1), .in_14_1(in_14_1),
        .out_valid(out_valid), .out_27(out_27), .out_28(out_28)
    );

    arf_accurate #(.TRUNC_BITS(2)) dut_t (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_1_0(in_s[0]), .in_2_0(in_s[1]), .in_3_0(in_s[2]), .in_4_0(in_s[3]),
        .in_5_0(in_s[4]), .in_6_0(in_s[5]), .in_7_0(in_s[6]), .in_8_0(in_s[7]),
        .in_13_1(in_13_1), .in_14_1(in_14_1),
        .out_valid(out_valid_t), .out_27(out_27_t), .out_28(out_28_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mt(input logic [63:0] a, input logic [15:0] c, input int t);
        logic [63:0] p;
        p = a * {{48{c[15]}}, c};
        return (p >> t) << t;
    endfunction

    function automatic exp_t model(input vec_t v, input int t);
        logic [15:0] c [8];
        logic [63:0] m [8];
        logic [63:0] a13, a14, a11, a12, a21, a22;
        exp_t r;
        c = '{16'd3, 16'd5, 16'd7, 16'd9, 16'd11, 16'd13, 16'd15, 16'd17};
        for (int i = 0; i < 8; i++)
            m[i] = mt({{48{v.s[i][15]}}, v.s[i]}, c[i], t);
        a11 = m[4] + m[5];
        a12 = m[6] + m[7];
        a13 = m[0] + m[1] + v.f13;
        a14 = m[2] + m[3] + v.f14;
        a21 = mt(a13, 16'd2, t) + mt(a14, 16'd4, t) + a11;
        a22 = mt(a13, 16'd3, t) + mt(a14, 16'd5, t) + a12;
        r.e27 = mt(a21, 16'd6, t) + mt(a22, 16'd8, t);
        r.e28 = mt(a21, 16'd7, t) + mt(a22, 16'd9, t);
        return r;
    endfunction

    function automatic vec_t mkvec(input int idx, input logic [15:0] val,
                                   input logic [63:0] f13, input logic [63:0] f14);
        vec_t v;
        v.s = '0;
        if (idx >= 0) v.s[idx] = val;
        v.f13 = f13;
        v.f14 = f14;
        return v;
    endfunction

    // Applies one input set for one clock; valid sets push their expected results.
    task automatic apply(input vec_t v, input logic vld, input logic [63:0] e27, input logic [63:0] e28);
        exp_t e;
        for (int i = 0; i < 8; i++) in_s[i] = v.s[i];
        in_13_1  = v.f13;
        in_14_1  = v.f14;
        in_valid = vld;
        if (vld) begin
            e.e27 = e27;
            e.e28 = e28;
            q_m.push_back(e);
            q_t.push_back(model(v, 2));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        n_vec++;
        if (out_valid !== 1'b0 || out_27 !== 64'd0 || out_28 !== 64'd0 || out_valid_t !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got valid=%b out_27=%0h out_28=%0h, required valid=0 outputs 0",
                     tag, out_valid, out_27, out_28);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            n_vec++;
            if (q_m.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got out_27=%0h out_28=%0h, required no output", out_27, out_28);
            end else begin
                e = q_m.pop_front();
                if (out_27 !== e.e27 || out_28 !== e.e28) begin
                    n_err++;
                    $display("FAIL exact_result: got %0d/%0d, required %0d/%0d",
                             $signed(out_27), $signed(out_28), $signed(e.e27), $signed(e.e28));
                end
            end
        end
        if (rst_n && out_valid_t) begin
            n_vec++;
            if (q_t.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid_trunc: got out_27=%0h, required no output", out_27_t);
            end else begin
                e = q_t.pop_front();
                if (out_27_t !== e.e27 || out_28_t !== e.e28) begin
                    n_err++;
                    $display("FAIL trunc_result: got %0d/%0d, required %0d/%0d",
                             $signed(out_27_t), $signed(out_28_t), $signed(e.e27), $signed(e.e28));
                end
                if (log_diff)
                    $display("trunc diff: out_27 %0d, out_28 %0d",
                             $signed(out_27 - out_27_t), $signed(out_28 - out_28_t));
            end
        end
    end

    vec_t v_set [5];
    logic [63:0] e27_set [5];
    logic [63:0] e28_set [5];

    initial begin
        vec_t  vz, vr;
        exp_t  er;
        int    budget;
        n_vec    = 0;
        n_err    = 0;
        log_diff = 1'b0;
        rst_n    = 1'b0;
        vz       = mkvec(-1, 16'd0, 64'd0, 64'd0);
        for (int i = 0; i < 8; i++) in_s[i] = '0;
        in_13_1  = '0;
        in_14_1  = '0;
        in_valid = 1'b1;

        v_set[0] = mkvec(0, 16'd1,    64'd0, 64'd0); e27_set[0] = 64'd108;  e28_set[0] = 64'd123;
        v_set[1] = mkvec(0, 16'hFFFF, 64'd0, 64'd0); e27_set[1] = -64'sd108; e28_set[1] = -64'sd123;
        v_set[2] = mkvec(-1, 16'd0,   64'd1, 64'd0); e27_set[2] = 64'd36;   e28_set[2] = 64'd41;
        v_set[3] = mkvec(-1, 16'd0,   64'd0, 64'd1); e27_set[3] = 64'd64;   e28_set[3] = 64'd73;
        v_set[4] = mkvec(6, 16'd1,    64'd0, 64'd0); e27_set[4] = 64'd120;  e28_set[4] = 64'd135;

        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset_hold");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply(vz, 1'b1, 64'd0, 64'd0);
        repeat (4) apply(vz, 1'b0, 64'd0, 64'd0);

        for (int i = 0; i < 5; i++) begin
            apply(v_set[i], 1'b1, e27_set[i], e28_set[i]);
            repeat (3) apply(vz, 1'b0, 64'd0, 64'd0);
        end

        for (int i = 0; i < 5; i++) apply(v_set[i], 1'b1, e27_set[i], e28_set[i]);
        repeat (4) apply(vz, 1'b0, 64'd0, 64'd0);

        for (int i = 0; i < 5; i++) begin
            apply(v_set[i], 1'b1, e27_set[i], e28_set[i]);
            if (i == 1) apply(vz, 1'b0, 64'd0, 64'd0);
        end
        repeat (4) apply(vz, 1'b0, 64'd0, 64'd0);

        // First set reaches the output register while two more are in flight.
        apply(v_set[0], 1'b1, e27_set[0], e28_set[0]);
        apply(v_set[2], 1'b1, e27_set[2], e28_set[2]);
        apply(v_set[4], 1'b1, e27_set[4], e28_set[4]);
        rst_n = 1'b0;
        #1;
        check_cleared("midstream_reset");
        q_m.delete();
        q_t.delete();
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset_held");
        rst_n = 1'b1;
        repeat (6) apply(vz, 1'b0, 64'd0, 64'd0);
        apply(v_set[3], 1'b1, e27_set[3], e28_set[3]);
        repeat (4) apply(vz, 1'b0, 64'd0, 64'd0);

        log_diff = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 8; i++) vr.s[i] = 16'($urandom);
            vr.f13 = {$urandom, $urandom};
            vr.f14 = {$urandom, $urandom};
            er = model(vr, 0);
            apply(vr, 1'b1, er.e27, er.e28);
        end

        budget = 0;
        while ((q_m.size() != 0 || q_t.size() != 0) && budget < 20) begin
            apply(vz, 1'b0, 64'd0, 64'd0);
            budget++;
        end
        n_vec++;
        if (q_m.size() != 0 || q_t.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d/%0d results outstanding, required 0",
                     q_m.size(), q_t.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
